// File: rtl/pipe_skid_reg.sv
// Pipeline-stage register with valid/ready handshake, one-entry skid buffer and flush.
// in_ready and out_valid come straight from flops, so in_ready never depends on out_ready.
module pipe_skid_reg #(
  parameter int WIDTH      = 32,
  parameter bit CLEAR_DATA = 1'b1,
  parameter int CNT_W      = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             flush,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_data,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_data,
  output logic [1:0]       occupancy,
  output logic [CNT_W-1:0] stall_cnt
);

  typedef enum logic [1:0] {
    EMPTY = 2'd0,
    HALF  = 2'd1,
    FULL  = 2'd2
  } occ_e;

  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  occ_e             state, state_nxt;
  logic             main_valid, skid_valid;
  logic [WIDTH-1:0] main_data, skid_data;
  logic [WIDTH-1:0] main_nxt, skid_nxt;
  logic             in_fire, out_fire;

  assign in_fire   = in_valid & in_ready;
  assign out_fire  = main_valid & out_ready;
  assign in_ready  = ~skid_valid;
  assign out_valid = main_valid;
  assign out_data  = main_data;
  assign occupancy = state;

  // Valid flags are kept as their own flops (decoded from the next state) so the
  // handshake outputs carry no combinational logic.
  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= EMPTY;
      main_valid <= 1'b0;
      skid_valid <= 1'b0;
    end else begin
      state      <= state_nxt;
      main_valid <= (state_nxt != EMPTY);
      skid_valid <= (state_nxt == FULL);
    end
  end

  always_comb begin
    state_nxt = state;
    if (flush) begin
      state_nxt = EMPTY;
    end else begin
      case (state)
        EMPTY: if (in_fire) state_nxt = HALF;
        HALF: begin
          if (in_fire && !out_fire)
            state_nxt = FULL;
          else if (out_fire && !in_fire)
            state_nxt = EMPTY;
        end
        FULL:    if (out_fire) state_nxt = HALF;
        default: state_nxt = EMPTY;
      endcase
    end
  end

  // Payload steering; with CLEAR_DATA an entry that empties is zeroed so bubbles read 0.
  always_comb begin
    main_nxt = main_data;
    skid_nxt = skid_data;
    if (flush) begin
      if (CLEAR_DATA) begin
        main_nxt = '0;
        skid_nxt = '0;
      end
    end else begin
      case (state)
        EMPTY: if (in_fire) main_nxt = in_data;
        HALF: begin
          if (out_fire) begin
            if (in_fire)
              main_nxt = in_data;
            else if (CLEAR_DATA)
              main_nxt = '0;
          end else if (in_fire) begin
            skid_nxt = in_data;
          end
        end
        FULL: begin
          if (out_fire) begin
            main_nxt = skid_data;
            if (CLEAR_DATA)
              skid_nxt = '0;
          end
        end
        default: begin
          if (CLEAR_DATA) begin
            main_nxt = '0;
            skid_nxt = '0;
          end
        end
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      if (CLEAR_DATA) begin
        main_data <= '0;
        skid_data <= '0;
      end
    end else begin
      main_data <= main_nxt;
      skid_data <= skid_nxt;
    end
  end

  // Back-pressure counter keeps running through flush; only reset clears it.
  always_ff @(posedge clk) begin
    if (rst)
      stall_cnt <= '0;
    else if (main_valid && !out_ready && stall_cnt != CNT_MAX)
      stall_cnt <= stall_cnt + CNT_W'(1);
  end

endmodule

// File: tb/tb_pipe_skid_reg.sv
// Self-checking bench for pipe_skid_reg: directed steps plus a random run against a
// queue scoreboard that also predicts occupancy, handshake flags and the stall counter.
module tb_pipe_skid_reg;

  localparam int W  = 32;
  localparam int CW = 3;

  logic          clk = 1'b0;
  logic          rst, flush, in_valid, in_ready, out_valid, out_ready;
  logic [W-1:0]  in_data, out_data;
  logic [1:0]    occupancy;
  logic [CW-1:0] stall_cnt;

  int           n_checks = 0;
  int           n_fail   = 0;
  logic         mon_en   = 1'b0;
  logic [W-1:0] sb[$];
  int           exp_stall = 0;

  always #5 clk = ~clk;

  pipe_skid_reg #(
    .WIDTH     (W),
    .CLEAR_DATA(1'b1),
    .CNT_W     (CW)
  ) dut (
    .clk      (clk),
    .rst      (rst),
    .flush    (flush),
    .in_valid (in_valid),
    .in_ready (in_ready),
    .in_data  (in_data),
    .out_valid(out_valid),
    .out_ready(out_ready),
    .out_data (out_data),
    .occupancy(occupancy),
    .stall_cnt(stall_cnt)
  );

  task automatic checkOutput(input string tag, input logic [W-1:0] obs, input logic [W-1:0] exp);
    n_checks++;
    assert (obs === exp)
    else begin
      n_fail++;
      $error("[TB] FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // Drives one cycle of inputs, then returns just after the edge that consumed them.
  task automatic applyStimulus(input logic iv, input logic [W-1:0] d, input logic ordy,
                               input logic fl, input logic rs);
    in_valid  = iv;
    in_data   = d;
    out_ready = ordy;
    flush     = fl;
    rst       = rs;
    @(posedge clk);
    #1;
  endtask

  // Scoreboard monitor: queue depth is the reference occupancy; head is the expected output.
  always @(negedge clk) begin : monitor
    int sz;
    if (mon_en) begin
      sz = sb.size();
      checkOutput("mon_in_ready", W'(in_ready), W'(sz != 2));
      checkOutput("mon_out_valid", W'(out_valid), W'(sz != 0));
      checkOutput("mon_occupancy", W'(occupancy), W'(sz));
      checkOutput("mon_stall_cnt", W'(stall_cnt), W'(exp_stall));
      if (sz == 0) begin
        checkOutput("mon_bubble", out_data, '0);
      end else begin
        checkOutput("mon_out_data", out_data, sb[0]);
        if (out_ready)
          void'(sb.pop_front());
      end
      if (sz != 0 && !out_ready && exp_stall < 7)
        exp_stall++;
      if (rst) begin
        sb.delete();
        exp_stall = 0;
      end else if (flush) begin
        sb.delete();
      end else if (in_valid && sz != 2) begin
        sb.push_back(in_data);
      end
    end
  end

  initial begin
    rst = 1'b1; flush = 1'b0; in_valid = 1'b0; in_data = '0; out_ready = 1'b0;
    @(posedge clk);
    #1;
    applyStimulus(1'b0, '0, 1'b0, 1'b0, 1'b1);
    checkOutput("rst_in_ready", W'(in_ready), 1);
    checkOutput("rst_out_valid", W'(out_valid), 0);
    checkOutput("rst_out_data", out_data, 0);
    checkOutput("rst_occupancy", W'(occupancy), 0);
    checkOutput("rst_stall_cnt", W'(stall_cnt), 0);
    mon_en = 1'b1;

    $display("[TB] streaming with out_ready high");
    applyStimulus(1'b1, 32'h11, 1'b1, 1'b0, 1'b0);
    checkOutput("stream_d1", out_data, 32'h11);
    checkOutput("stream_occ1", W'(occupancy), 1);
    applyStimulus(1'b1, 32'h22, 1'b1, 1'b0, 1'b0);
    checkOutput("stream_d2", out_data, 32'h22);
    checkOutput("stream_occ2", W'(occupancy), 1);
    applyStimulus(1'b1, 32'h33, 1'b1, 1'b0, 1'b0);
    checkOutput("stream_d3", out_data, 32'h33);
    checkOutput("stream_occ3", W'(occupancy), 1);
    applyStimulus(1'b0, '0, 1'b1, 1'b0, 1'b0);
    checkOutput("stream_drained_valid", W'(out_valid), 0);
    checkOutput("stream_drained_data", out_data, 0);
    checkOutput("stream_stall", W'(stall_cnt), 0);

    $display("[TB] back-pressure into skid");
    applyStimulus(1'b1, 32'hA1, 1'b0, 1'b0, 1'b0);
    checkOutput("bp_in_ready1", W'(in_ready), 1);
    applyStimulus(1'b1, 32'hA2, 1'b0, 1'b0, 1'b0);
    checkOutput("bp_in_ready2", W'(in_ready), 0);
    checkOutput("bp_occ_full", W'(occupancy), 2);
    applyStimulus(1'b1, 32'hA3, 1'b0, 1'b0, 1'b0);
    checkOutput("bp_hold_data", out_data, 32'hA1);
    checkOutput("bp_hold_occ", W'(occupancy), 2);
    applyStimulus(1'b1, 32'hA3, 1'b1, 1'b0, 1'b0);
    checkOutput("bp_rel_d2", out_data, 32'hA2);
    checkOutput("bp_rel_in_ready", W'(in_ready), 1);
    applyStimulus(1'b1, 32'hA3, 1'b1, 1'b0, 1'b0);
    checkOutput("bp_rel_d3", out_data, 32'hA3);
    applyStimulus(1'b0, '0, 1'b1, 1'b0, 1'b0);
    checkOutput("bp_empty", W'(out_valid), 0);
    checkOutput("bp_stall", W'(stall_cnt), 2);

    $display("[TB] flush while full with input offered");
    applyStimulus(1'b1, 32'hB1, 1'b0, 1'b0, 1'b0);
    applyStimulus(1'b1, 32'hB2, 1'b0, 1'b0, 1'b0);
    checkOutput("fl_pre_occ", W'(occupancy), 2);
    applyStimulus(1'b1, 32'hFF, 1'b0, 1'b1, 1'b0);
    checkOutput("fl_out_valid", W'(out_valid), 0);
    checkOutput("fl_occ", W'(occupancy), 0);
    checkOutput("fl_out_data", out_data, 0);
    checkOutput("fl_in_ready", W'(in_ready), 1);
    checkOutput("fl_stall", W'(stall_cnt), 4);
    applyStimulus(1'b0, '0, 1'b0, 1'b0, 1'b0);
    checkOutput("fl_after_valid", W'(out_valid), 0);

    $display("[TB] stall counter saturation");
    applyStimulus(1'b0, '0, 1'b0, 1'b0, 1'b1);
    applyStimulus(1'b1, 32'hC1, 1'b0, 1'b0, 1'b0);
    checkOutput("sat_start", W'(stall_cnt), 0);
    for (int i = 1; i <= 10; i++) begin
      applyStimulus(1'b0, '0, 1'b0, 1'b0, 1'b0);
      checkOutput("sat_count", W'(stall_cnt), W'((i < 7) ? i : 7));
    end
    applyStimulus(1'b0, '0, 1'b0, 1'b0, 1'b1);
    checkOutput("sat_rst", W'(stall_cnt), 0);
    checkOutput("sat_rst_occ", W'(occupancy), 0);

    $display("[TB] reset while full");
    applyStimulus(1'b1, 32'hD1, 1'b0, 1'b0, 1'b0);
    applyStimulus(1'b1, 32'hD2, 1'b0, 1'b0, 1'b0);
    checkOutput("rf_pre_in_ready", W'(in_ready), 0);
    applyStimulus(1'b1, 32'hEE, 1'b1, 1'b0, 1'b1);
    checkOutput("rf_in_ready", W'(in_ready), 1);
    checkOutput("rf_out_valid", W'(out_valid), 0);
    checkOutput("rf_out_data", out_data, 0);
    checkOutput("rf_occ", W'(occupancy), 0);
    checkOutput("rf_stall", W'(stall_cnt), 0);

    $display("[TB] random traffic");
    for (int i = 0; i < 10000; i++) begin
      applyStimulus(1'($urandom_range(0, 1)), W'($urandom), 1'($urandom_range(0, 1)),
                    1'($urandom_range(0, 63) == 0), 1'b0);
    end
    for (int i = 0; i < 3; i++)
      applyStimulus(1'b0, '0, 1'b1, 1'b0, 1'b0);
    checkOutput("drain_queue", W'(sb.size()), 0);
    checkOutput("drain_valid", W'(out_valid), 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
